// File: rtl/dram_line_fetcher.sv
// Scanline prefetcher: walks one display line of 32-bit words out of SDRAM through
// arbiter port 1 and buffers them in a show-ahead FIFO for the video output stage.
module dram_line_fetcher #(
  parameter logic [23:0] BASE_ADDR      = 24'h100000,
  parameter int          WORDS_PER_LINE = 64,
  parameter int          LINES          = 240,
  parameter logic [23:0] LINE_STRIDE    = 24'd128,
  parameter int          FIFO_DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        line_start,
  output logic [23:0]                 addr1,
  output logic                        req_read1,
  input  logic [31:0]                 data1,
  input  logic                        data_valid1,
  input  logic                        pop,
  output logic [31:0]                 pop_data,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic [9:0]                  line_index,
  output logic                        underflow,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_GAP} state_t;

  state_t        state, next_state;
  logic [23:0]   line_base;
  logic [9:0]    words_left;
  logic          pending;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic full, do_pop;
  logic start_line, frame_reset, push, advance, line_done, set_pending;

  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign pop_data   = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign req_read1  = (state == S_REQ);
  assign busy       = (state != S_IDLE);
  assign do_pop     = pop && !fifo_empty && !frame_reset;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // A frame restart during an outstanding read is deferred to GAP exit so the
  // arbiter handshake always completes; the returning word is dropped.
  always_comb begin
    next_state  = state;
    start_line  = 1'b0;
    frame_reset = 1'b0;
    push        = 1'b0;
    advance     = 1'b0;
    line_done   = 1'b0;
    set_pending = 1'b0;
    unique case (state)
      S_IDLE: begin
        frame_reset = frame_start;
        if (line_start) begin
          start_line = 1'b1;
          next_state = (full && !frame_start) ? S_WAIT : S_REQ;
        end
      end
      S_WAIT: begin
        if (frame_start) begin
          frame_reset = 1'b1;
          next_state  = S_IDLE;
        end else if (!full) begin
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        set_pending = frame_start;
        if (data_valid1) begin
          push       = !(pending || frame_start);
          advance    = 1'b1;
          next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (pending || frame_start) begin
          frame_reset = 1'b1;
          next_state  = S_IDLE;
        end else if (words_left == 10'd0) begin
          line_done  = 1'b1;
          next_state = S_IDLE;
        end else begin
          next_state = full ? S_WAIT : S_REQ;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr1      <= BASE_ADDR;
      words_left <= 10'd0;
      line_base  <= BASE_ADDR;
      line_index <= 10'd0;
      pending    <= 1'b0;
      underflow  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_line) begin
        addr1      <= frame_reset ? BASE_ADDR : line_base;
        words_left <= 10'(WORDS_PER_LINE);
      end else if (advance) begin
        addr1      <= addr1 + 24'd2;
        words_left <= words_left - 10'd1;
      end

      if (frame_reset) begin
        line_index <= 10'd0;
        line_base  <= BASE_ADDR;
      end else if (line_done) begin
        if (line_index == 10'(LINES - 1)) begin
          line_index <= 10'd0;
          line_base  <= BASE_ADDR;
        end else begin
          line_index <= line_index + 10'd1;
          line_base  <= line_base + LINE_STRIDE;
        end
      end

      if (frame_reset)      pending <= 1'b0;
      else if (set_pending) pending <= 1'b1;

      if (line_start && busy) overrun <= 1'b1;
      if (pop && fifo_empty)  underflow <= 1'b1;
    end
  end

  // Storage needs no reset: pop_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_line_fetcher.sv
// Self-checking bench for dram_line_fetcher: directed corner sequences, a frame-wrap
// vector table and a randomized run against a word-index arithmetic reference model.
module tb_dram_line_fetcher;

  localparam logic [23:0] BASE   = 24'h100000;
  localparam int          WPL    = 6;
  localparam int          NLINES = 3;
  localparam logic [23:0] STRIDE = 24'd128;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, line_start, pop;
  logic [23:0] addr1;
  logic        req_read1;
  logic [31:0] data1;
  logic        data_valid1;
  logic [31:0] pop_data;
  logic        fifo_empty;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [9:0]  line_index;
  logic        underflow, overrun;

  dram_line_fetcher #(
    .BASE_ADDR(BASE), .WORDS_PER_LINE(WPL), .LINES(NLINES),
    .LINE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .addr1(addr1), .req_read1(req_read1), .data1(data1), .data_valid1(data_valid1),
    .pop(pop), .pop_data(pop_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .busy(busy), .line_index(line_index), .underflow(underflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        outstanding;
  logic [23:0] out_addr;
  int          lat_cnt;
  logic        rand_lat;
  logic [23:0] issued[$];
  logic        model_on;
  int          delivered, popped, last_dv_cyc;
  logic        underflow_exp;

  typedef struct {
    logic        fs;
    logic [23:0] exp_addr;
    logic [9:0]  exp_index;
  } wrap_vec_t;

  wrap_vec_t tbl [5];

  function automatic logic [31:0] word_of(input logic [23:0] a);
    return {8'hD0, a};
  endfunction

  // Address of the g-th word fetched since a frame restart.
  function automatic logic [23:0] addr_of(input int g);
    logic [23:0] a;
    a = BASE + 24'((g / WPL) % NLINES) * STRIDE + 24'(2 * (g % WPL));
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Single-outstanding arbiter with data = tagged address.
  task automatic arbStep();
    data_valid1 = 1'b0;
    if (!rst_n) begin
      outstanding = 1'b0;
      return;
    end
    if (outstanding) begin
      checkOutput("req_held", 32'(req_read1), 32'd1);
      checkOutput("addr_stable", 32'(addr1), 32'(out_addr));
      if (lat_cnt <= 1) begin
        data_valid1 = 1'b1;
        data1       = word_of(out_addr);
        outstanding = 1'b0;
      end else begin
        lat_cnt--;
      end
    end else if (req_read1) begin
      outstanding = 1'b1;
      out_addr    = addr1;
      issued.push_back(addr1);
      lat_cnt = rand_lat ? int'($urandom_range(1, 4)) : 3;
      if (model_on) checkOutput("rand_req_addr", 32'(addr1), 32'(addr_of(delivered)));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (data_valid1) last_dv_cyc = cyc;
    if (model_on) begin
      if (pop) begin
        if (delivered == popped) underflow_exp = 1'b1;
        else popped++;
      end
      if (data_valid1) delivered++;
      checkOutput("rand_count", 32'(fifo_count), 32'(delivered - popped));
      checkOutput("rand_empty", 32'(fifo_empty), 32'(delivered == popped));
      checkOutput("rand_underflow", 32'(underflow), 32'(underflow_exp));
      checkOutput("rand_overrun", 32'(overrun), 32'd0);
      if (!busy) checkOutput("rand_line_index", 32'(line_index), 32'((delivered / WPL) % NLINES));
    end
    arbStep();
  endtask

  task automatic applyStimulus(input logic fs, input logic ls, input logic p);
    frame_start = fs;
    line_start  = ls;
    pop         = p;
    tick();
    frame_start = 1'b0;
    line_start  = 1'b0;
    pop         = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && !fifo_empty; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"}, 32'(req_read1), 32'd0);
    checkOutput({tag, "_addr"}, 32'(addr1), 32'(BASE));
    checkOutput({tag, "_count"}, 32'(fifo_count), 32'd0);
    checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_index"}, 32'(line_index), 32'd0);
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    checkOutput({tag, "_pop_data"}, pop_data, 32'd0);
  endtask

  // Pops whenever a word is present until the current line fetch finishes.
  task automatic runLineOut(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      pop = !fifo_empty;
      tick();
      n++;
    end
    pop = 1'b0;
    if (busy) timeoutFail(tag);
  endtask

  initial begin
    int n, e, busy_fall, max_cnt;

    tbl[0] = '{1'b1, BASE,                10'd1};
    tbl[1] = '{1'b0, BASE + STRIDE,       10'd2};
    tbl[2] = '{1'b0, BASE + 24'd2*STRIDE, 10'd0};
    tbl[3] = '{1'b0, BASE,                10'd1};
    tbl[4] = '{1'b0, BASE + STRIDE,       10'd2};

    rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; pop = 1'b0;
    data_valid1 = 1'b0; data1 = 32'd0; outstanding = 1'b0; out_addr = 24'd0; lat_cnt = 0;
    model_on = 1'b0; rand_lat = 1'b0; delivered = 0; popped = 0; underflow_exp = 1'b0;
    last_dv_cyc = 0;
    tick();
    tick();
    checkResetValues("reset");
    rst_n = 1'b1;
    tick();

    // Single line with backpressure: 6 words into a 4-deep FIFO, no pops at first.
    issued.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("line_busy", 32'(busy), 32'd1);
    checkOutput("line_req", 32'(req_read1), 32'd1);
    checkOutput("line_addr0", 32'(addr1), 32'(BASE));
    n = 0;
    while (!(fifo_count == 3'd4 && !req_read1) && n < 200) begin tick(); n++; end
    if (n >= 200) timeoutFail("bp_fill");
    repeat (3) tick();
    checkOutput("bp_req_low", 32'(req_read1), 32'd0);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    checkOutput("bp_count", 32'(fifo_count), 32'd4);
    checkOutput("bp_issued", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      checkOutput($sformatf("line_addr%0d", i), 32'(issued[i]), 32'(BASE + 24'(2 * i)));
    checkOutput("bp_head", pop_data, word_of(BASE));
    applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    while (!req_read1 && n < 2) begin tick(); n++; end
    checkOutput("bp_resume", 32'(req_read1), 32'd1);
    e = 1; n = 0; busy_fall = -1;
    while ((busy || !fifo_empty) && n < 400) begin
      if (!fifo_empty) begin
        checkOutput("bp_order", pop_data, word_of(BASE + 24'(2 * e)));
        e++;
        pop = 1'b1;
      end else begin
        pop = 1'b0;
      end
      tick();
      n++;
      if (!busy && busy_fall < 0) busy_fall = cyc;
    end
    pop = 1'b0;
    if (n >= 400) timeoutFail("bp_drain");
    checkOutput("bp_words", 32'(e), 32'(WPL));
    checkOutput("bp_busy_timing", 32'(busy_fall - last_dv_cyc), 32'd1);
    checkOutput("line_index_1", 32'(line_index), 32'd1);

    // Frame wrap table, first entry also combines frame_start with line_start.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(tbl[v].fs, 1'b1, 1'b0);
      checkOutput($sformatf("wrap%0d_req", v), 32'(req_read1), 32'd1);
      checkOutput($sformatf("wrap%0d_addr", v), 32'(addr1), 32'(tbl[v].exp_addr));
      runLineOut("wrap_line");
      checkOutput($sformatf("wrap%0d_index", v), 32'(line_index), 32'(tbl[v].exp_index));
      drain();
    end

    // frame_start while a read is outstanding.
    issued.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (issued.size() < 3 && n < 100) begin tick(); n++; end
    if (n >= 100) timeoutFail("mid_wait");
    checkOutput("mid_count_before", 32'(fifo_count), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("mid_hold_count", 32'(fifo_count), 32'd2);
    max_cnt = fifo_count;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
      if (fifo_count > max_cnt) max_cnt = fifo_count;
    end
    if (busy) timeoutFail("mid_idle");
    checkOutput("mid_discard", 32'(max_cnt), 32'd2);
    checkOutput("mid_issued", 32'(issued.size()), 32'd3);
    checkOutput("mid_empty", 32'(fifo_empty), 32'd1);
    checkOutput("mid_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_index", 32'(line_index), 32'd0);
    checkOutput("mid_req", 32'(req_read1), 32'd0);

    // Sticky error flags.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("uf_flag", 32'(underflow), 32'd1);
    checkOutput("uf_count", 32'(fifo_count), 32'd0);
    issued.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ov_flag", 32'(overrun), 32'd1);
    runLineOut("ov_line");
    repeat (4) tick();
    checkOutput("ov_busy", 32'(busy), 32'd0);
    checkOutput("ov_issued", 32'(issued.size()), 32'(WPL));
    if (issued.size() == WPL) checkOutput("ov_last_addr", 32'(issued[WPL-1]), 32'(BASE + 24'd10));
    checkOutput("ov_index", 32'(line_index), 32'd1);
    checkOutput("uf_sticky", 32'(underflow), 32'd1);
    checkOutput("ov_sticky", 32'(overrun), 32'd1);
    drain();
    rst_n = 1'b0;
    tick();
    checkOutput("flags_clr_uf", 32'(underflow), 32'd0);
    checkOutput("flags_clr_ov", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a fetch with words buffered.
    issued.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    n = 0;
    while (issued.size() < 3 && n < 100) begin tick(); n++; end
    if (n >= 100) timeoutFail("rst_wait");
    checkOutput("rst_pre_req", 32'(req_read1), 32'd1);
    checkOutput("rst_pre_count", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    tick();
    checkResetValues("rst_mid");
    rst_n = 1'b1;
    tick();

    // Randomized run against the reference model.
    delivered = 0; popped = 0; underflow_exp = 1'b0;
    model_on = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      line_start = (!busy && $urandom_range(0, 7) == 0);
      pop = ($urandom_range(0, 99) < 40);
      if (pop && delivered != popped)
        checkOutput("rand_pop_data", pop_data, word_of(addr_of(popped)));
      tick();
    end
    line_start = 1'b0;
    pop = 1'b0;
    model_on = 1'b0;
    if (delivered < 2 * WPL) timeoutFail("rand_progress");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
